// File: rtl/sm4_sbox_arbiter_if.sv
// sm4_sbox_arbiter_if -- handshake bundle for sm4_sbox_arbiter.
//   a_*   : round-function word request   (valid/data in, ready out)
//   b_*   : key-expansion word request    (valid/data in, ready out)
//   rsp_* : substituted word + source id  (valid/data/id out, ready in)
// Modports: slave = the arbiter, master = requesters/consumer.
interface sm4_sbox_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, rsp_ready,
    output a_ready, b_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, rsp_ready,
    input  a_ready, b_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/sm4_sbox_arbiter.sv
// sm4_sbox_arbiter -- two-port round-robin arbiter in front of a single
// time-shared SM4 S-box computing the 32-bit tau transform, one byte/cycle.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : sm4_sbox_arbiter_if.slave (A/B requests, response channel)
//   busy  : high whenever not IDLE
// Parameter PRIO_RESET: port holding priority after reset (0 = A, 1 = B).
// Macro SM4_SBOX_ARBITER_OUT_REG_EN: registers the S-box output before the
// byte-lane write, adding a PIPE state (latency T+6 instead of T+5).
module sm4_sbox_arbiter #(
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  sm4_sbox_arbiter_if.slave         bus,
  output logic                      busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] PIPE = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] result_q;
  logic        id_q;
  logic        ptr_q;     // 0 = A holds priority, 1 = B
  logic        a_gnt, b_gnt, accept;
  logic [7:0]  sbox_in, sbox_out;

`ifdef SM4_SBOX_ARBITER_OUT_REG_EN
  logic [7:0]  sbox_q;
  logic [1:0]  lane_q;
  logic        pend_q;    // sbox_q holds a byte still to be written to lane_q
`endif

  // Grants are gated by rst so the readies read 0 while reset is held.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst && state_q == IDLE) begin
      a_gnt = bus.a_valid && (!bus.b_valid || !ptr_q);
      b_gnt = bus.b_valid && (!bus.a_valid ||  ptr_q);
    end
  end

  assign accept      = a_gnt || b_gnt;
  assign bus.a_ready = a_gnt;
  assign bus.b_ready = b_gnt;

  // The single shared S-box.
  assign sbox_in  = word_q[{cnt_q, 3'b000} +: 8];
  assign sbox_out = SBOX[sbox_in];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SUB;
      SUB: begin
        if (cnt_q == 2'd0) begin
`ifdef SM4_SBOX_ARBITER_OUT_REG_EN
          state_d = PIPE;
`else
          state_d = DONE;
`endif
        end
      end
      PIPE: state_d = DONE;
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
      id_q     <= 1'b0;
      ptr_q    <= (PRIO_RESET != 0);
`ifdef SM4_SBOX_ARBITER_OUT_REG_EN
      sbox_q   <= '0;
      lane_q   <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q <= a_gnt ? bus.a_data : bus.b_data;
        id_q   <= b_gnt;
        ptr_q  <= a_gnt;   // priority passes to the port not granted
        cnt_q  <= 2'd3;
      end else if (state_q == SUB) begin
        cnt_q <= cnt_q - 2'd1;
      end
`ifdef SM4_SBOX_ARBITER_OUT_REG_EN
      // Lane write trails the lookup by one cycle; the last byte lands in PIPE.
      pend_q <= (state_q == SUB);
      lane_q <= cnt_q;
      sbox_q <= sbox_out;
      if (pend_q) result_q[{lane_q, 3'b000} +: 8] <= sbox_q;
`else
      if (state_q == SUB) result_q[{cnt_q, 3'b000} +: 8] <= sbox_out;
`endif
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = bus.rsp_valid ? result_q : '0;
  assign bus.rsp_id    = bus.rsp_valid && id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/sm4_sbox_arbiter.md
SM4_SBOX_ARBITER -- requirements
Module: sm4_sbox_arbiter

Interface
REQ-001 SHALL have parameter PRIO_RESET, default 0, selecting the port that holds round-robin priority after reset (0 = port A, 1 = port B).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports a_valid / a_ready / a_data: input 1 / output 1 / input 32, the round-function word request.
REQ-005 SHALL have ports b_valid / b_ready / b_data: input 1 / output 1 / input 32, the key-expansion word request.
REQ-006 SHALL have ports rsp_valid / rsp_ready / rsp_data / rsp_id: output 1 / input 1 / output 32 / output 1, the substituted word and its source (0 = A, 1 = B).
REQ-007 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-008 SHALL instantiate exactly one 8-bit SM4 S-box and time-share it, one byte per cycle, to perform the 32-bit tau transform.
REQ-009 SHALL implement states IDLE -> SUB -> DONE -> IDLE, plus SUB -> PIPE -> DONE when SBOX_OUT_REG_EN is defined.
REQ-010 SHALL assert a_ready or b_ready only in IDLE, at most one per cycle, combinationally from the valids and the priority pointer.
REQ-011 With both valids high in IDLE, the pointer holder SHALL be granted; with one valid high, that port SHALL be granted regardless of the pointer.
REQ-012 On each accepted handshake the pointer SHALL move to the non-granted port; with no grant it SHALL hold.
REQ-013 An accept in cycle T SHALL latch the word and rsp_id, then enter SUB with a 2-bit byte counter at 3.
REQ-014 In SUB, byte[8*cnt+7:8*cnt] SHALL drive the S-box, and its output SHALL be written to the same byte lane of the result register.
REQ-015 cnt SHALL count 3, 2, 1, 0 over cycles T+1..T+4, and SUB SHALL exit after cnt = 0.
REQ-016 rsp_valid SHALL rise in cycle T+5 (T+6 with SBOX_OUT_REG_EN).
REQ-017 rsp_data and rsp_id SHALL be stable while rsp_valid is high and rsp_ready is low.
REQ-018 The block SHALL leave DONE for IDLE on the cycle after rsp_valid and rsp_ready are both high; the next accept is possible in that IDLE cycle.
REQ-019 Valid deassertion by a requester before its handshake SHALL be permitted and SHALL not corrupt state.
REQ-020 Requests arriving while busy SHALL be held off (ready low), not dropped.
REQ-021 rsp_data SHALL read 0 whenever rsp_valid is low.

Reset
REQ-022 On rst high: state IDLE; cnt 0; result and word registers 0; pointer = PRIO_RESET; outputs a_ready, b_ready, rsp_valid, rsp_data, rsp_id and busy all 0.
REQ-023 rst asserted mid-SUB, PIPE or DONE SHALL abort the operation, discard the in-flight word, and produce no response after release.
REQ-024 The first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-025 Macro SM4_SBOX_ARBITER_OUT_REG_EN (referred to above as SBOX_OUT_REG_EN) SHALL control an output register on the S-box path.
REQ-026 When defined: S-box output SHALL be registered before byte-lane write; lanes land one cycle later; a PIPE cycle precedes DONE; latency T+6.
REQ-027 When undefined: combinational S-box-to-lane write; no PIPE state; latency T+5.

Verification
REQ-028 Reset, a_valid=1, a_data=0x00010203, rsp_ready=1 -> rsp_data=0xd690e9fe, rsp_id=0, rsp_valid at T+5 (T+6 with macro).
REQ-029 a_valid and b_valid high together from reset with PRIO_RESET=0, a_data=0x12345678, b_data=0xffff0000 -> A first (0x9ac9da4c, id 0), then B (0x4848d6d6, id 1).
REQ-030 Both ports continuously valid for 6 words -> grants alternate A, B, A, B, A, B; no port is granted twice in a row.
REQ-031 rsp_ready held low 10 cycles during DONE, b_valid high -> rsp_data stable, b_ready low throughout; B accepted in the IDLE cycle after the response handshake.
REQ-032 rst pulsed in cycle T+2 of an A transaction -> all outputs 0 immediately; no rsp_valid afterwards; a fresh request completes correctly.
REQ-033 a_data=0xabababab -> 0xabababab (S-box fixed point 0xab->0xab), confirming all four lanes are written.
